// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the serial configuration scheduler.
//   - default parameter values (requesters, bit period, reset hold, field widths)
//   - FSM state encoding
//   - max3(): constant helper used to size the shared bit counter
package spi_cfg_pkg;

    localparam int DEF_NREQ      = 3;
    localparam int DEF_DIV       = 256;
    localparam int DEF_GRST_BITS = 40;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_DATA_W    = 30;

    typedef enum logic [2:0] {
        ST_GRST_HOLD = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ADDR      = 3'd2,
        ST_DATA      = 3'd3,
        ST_GUARD     = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_cfg_scheduler_if.sv
// Bundle of the requester-side and serial-side signals of spi_cfg_scheduler.
//   master modport: requester/driver view (drives req/addr/data, observes the rest)
//   slave modport : scheduler view (consumes req/addr/data, drives ack and the link)
// Handshake: req[i] is a level held by requester i together with its addr/data
// slices; ack[i] is a single-cycle pulse issued when the scheduler captures
// those slices. After ack[i] the requester may change its slices or drop req[i]
// freely; a req that is low at the capturing tick is never granted.
interface spi_cfg_scheduler_if
    import spi_cfg_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] data;
    logic [NREQ-1:0]        ack;
    logic                   grst;
    logic                   sin;
    logic                   regsel;
    logic                   sclk_en;
    logic                   busy;

    modport master (
        output req, addr, data,
        input  ack, grst, sin, regsel, sclk_en, busy
    );

    modport slave (
        input  req, addr, data,
        output ack, grst, sin, regsel, sclk_en, busy
    );

endinterface

// File: rtl/spi_bit_tick.sv
// Bit-period tick generator.
//   SCLK : system clock
//   RST  : asynchronous active-low reset (clears the divider)
//   TICK : high for one SCLK cycle out of every DIV cycles
// DIV is a power of two, so the divider is a free-running counter that
// wraps naturally and the tick is the all-ones decode of it.
module spi_bit_tick
    import spi_cfg_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic SCLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign TICK = &div_cnt;

endmodule

// File: rtl/spi_cfg_scheduler.sv
// Round-robin scheduler for a shared serial configuration link.
//   SCLK    : system clock
//   RST     : asynchronous active-low reset
//   REQ     : per-requester level request
//   ADDR    : flattened slave addresses, requester i in slice i
//   DATA    : flattened data words, requester i in slice i
//   ACK     : one-cycle capture pulse to the granted requester
//   GRST    : global slave reset, held high for GRST_BITS bit periods after reset
//   SIN     : serial data (address MSB-first, then data LSB-first)
//   REGSEL  : high during the slave-select (address) phase
//   SCLK_EN : serial clock gate, high only while a bit is driven
//   BUSY    : high from grant until the end of the guard bit
// Handshake: REQ[i] is a level; ACK[i] pulses for one cycle when the slices of
// requester i are captured. Captured values are held internally, so the
// requester may change ADDR/DATA or drop REQ any time after ACK.
// A frame is ADDR_W address bits, DATA_W data bits and one guard bit; all
// state and link outputs change only on a bit tick.
module spi_cfg_scheduler
    import spi_cfg_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DIV       = DEF_DIV,
    parameter int GRST_BITS = DEF_GRST_BITS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                   SCLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        REQ,
    input  logic [NREQ*ADDR_W-1:0] ADDR,
    input  logic [NREQ*DATA_W-1:0] DATA,
    output logic [NREQ-1:0]        ACK,
    output logic                   GRST,
    output logic                   SIN,
    output logic                   REGSEL,
    output logic                   SCLK_EN,
    output logic                   BUSY
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(max3(GRST_BITS, ADDR_W, DATA_W) + 1);

    localparam logic [CNT_W-1:0] GRST_LAST = CNT_W'(GRST_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREQ - 1);

    logic              tick;
    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  rr_ptr;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    spi_bit_tick #(.DIV(DIV)) u_tick (
        .SCLK (SCLK),
        .RST  (RST),
        .TICK (tick)
    );

    // Round-robin search starting at rr_ptr. The loop runs from the farthest
    // offset down to the nearest so the nearest requesting index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (REQ[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign cap_addr = ADDR[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign cap_data = DATA[int'(grant_idx)*DATA_W +: DATA_W];

    // The bit counter holds at all-ones rather than wrapping.
    assign cnt_inc = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_GRST_HOLD;
            bit_cnt <= '0;
            rr_ptr  <= '0;
            addr_sh <= '0;
            data_sh <= '0;
            ACK     <= '0;
            GRST    <= 1'b1;
            SIN     <= 1'b0;
            REGSEL  <= 1'b0;
            SCLK_EN <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            ACK <= '0;
            if (tick) begin
                case (state)
                    ST_GRST_HOLD: begin
                        if (bit_cnt == GRST_LAST) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            GRST    <= 1'b0;
                        end else begin
                            bit_cnt <= cnt_inc;
                        end
                    end
                    ST_IDLE: begin
                        if (grant_valid) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                            ACK     <= NREQ'(1) << grant_idx;
                            rr_ptr  <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                            // First address bit goes out now; the rest
                            // are kept left-aligned in the shifter.
                            SIN     <= cap_addr[ADDR_W-1];
                            addr_sh <= cap_addr << 1;
                            data_sh <= cap_data;
                            REGSEL  <= 1'b1;
                            SCLK_EN <= 1'b1;
                            BUSY    <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (bit_cnt == ADDR_LAST) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            REGSEL  <= 1'b0;
                            SIN     <= data_sh[0];
                            data_sh <= data_sh >> 1;
                        end else begin
                            bit_cnt <= cnt_inc;
                            SIN     <= addr_sh[ADDR_W-1];
                            addr_sh <= addr_sh << 1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            state   <= ST_GUARD;
                            bit_cnt <= '0;
                            SIN     <= 1'b0;
                            SCLK_EN <= 1'b0;
                        end else begin
                            bit_cnt <= cnt_inc;
                            SIN     <= data_sh[0];
                            data_sh <= data_sh >> 1;
                        end
                    end
                    ST_GUARD: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                    default: begin
                        state <= ST_GRST_HOLD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_scheduler.sv
// Directed bench for spi_cfg_scheduler with default parameters.
module tb_spi_cfg_scheduler;
    import spi_cfg_pkg::*;

    localparam int NREQ      = DEF_NREQ;
    localparam int DIV       = DEF_DIV;
    localparam int GRST_BITS = DEF_GRST_BITS;
    localparam int ADDR_W    = DEF_ADDR_W;
    localparam int DATA_W    = DEF_DATA_W;

    // ---------------- clock / reset ----------------
    logic sclk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    int   ack_pulses;

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Cycles since reset release; the DUT ticks on every posedge where this
    // reaches a multiple of DIV.
    always @(posedge sclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    spi_cfg_scheduler_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_cfg_scheduler #(
        .NREQ(NREQ), .DIV(DIV), .GRST_BITS(GRST_BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .SCLK    (sclk),
        .RST     (rst_n),
        .REQ     (bus.req),
        .ADDR    (bus.addr),
        .DATA    (bus.data),
        .ACK     (bus.ack),
        .GRST    (bus.grst),
        .SIN     (bus.sin),
        .REGSEL  (bus.regsel),
        .SCLK_EN (bus.sclk_en),
        .BUSY    (bus.busy)
    );

    // ---------------- driver tasks ----------------
    task automatic step_cycle();
        @(posedge sclk);
        #1;
        ack_pulses += $countones(bus.ack);
    endtask

    // Advance to just after the next bit tick (bounded by DIV cycles).
    task automatic to_tick();
        do step_cycle(); while (cyc % DIV != 0);
    endtask

    task automatic set_slice(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.addr[idx*ADDR_W +: ADDR_W] = a;
        bus.data[idx*DATA_W +: DATA_W] = d;
    endtask

    task automatic release_reset();
        @(negedge sclk);
        rst_n = 1'b1;
    endtask

    // GRST high for GRST_BITS ticks after release, link quiet throughout.
    task automatic check_grst_hold(input string tag);
        logic [4:0] exp_v;
        for (int t = 1; t <= GRST_BITS; t++) begin
            to_tick();
            exp_v = {(t < GRST_BITS) ? 1'b1 : 1'b0, 4'b0000};
            checks++;
            if ({bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy} !== exp_v) begin
                errors++;
                $display("FAIL %s tick %0d {grst,sin,regsel,sclk_en,busy}: got %b expected %b",
                         tag, t, {bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy}, exp_v);
            end
        end
    endtask

    // Checks one complete frame starting at the next tick (the grant tick).
    task automatic run_frame(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input bit drop_req, input bit scramble, input string tag);
        logic [NREQ-1:0] exp_ack;
        logic [4:0]      exp_v;
        logic [4:0]      got_v;
        exp_ack = '0;
        exp_ack[idx] = 1'b1;
        to_tick();
        checks++;
        if (bus.ack !== exp_ack) begin
            errors++;
            $display("FAIL %s grant ack: got %b expected %b", tag, bus.ack, exp_ack);
        end
        if (drop_req) bus.req[idx] = 1'b0;
        ack_pulses = 0;
        step_cycle();
        checks++;
        if (bus.ack !== '0) begin
            errors++;
            $display("FAIL %s ack width: got %b expected %b", tag, bus.ack, {NREQ{1'b0}});
        end
        if (scramble) set_slice(idx, ~a, ~d);
        // k counts ticks from the grant; k=0 (the first address bit) is
        // checked here, 1..4 address, 5..34 data, 35 guard, 36 idle.
        got_v = {bus.grst, bus.busy, bus.sclk_en, bus.regsel, bus.sin};
        exp_v = {1'b0, 1'b1, 1'b1, 1'b1, a[ADDR_W-1]};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s tick 0 {grst,busy,sclk_en,regsel,sin}: got %b expected %b", tag, got_v, exp_v);
        end
        for (int k = 1; k <= ADDR_W + DATA_W + 1; k++) begin
            to_tick();
            if (k < ADDR_W)
                exp_v = {1'b0, 1'b1, 1'b1, 1'b1, a[ADDR_W-1-k]};
            else if (k < ADDR_W + DATA_W)
                exp_v = {1'b0, 1'b1, 1'b1, 1'b0, d[k-ADDR_W]};
            else if (k == ADDR_W + DATA_W)
                exp_v = 5'b01000;
            else
                exp_v = 5'b00000;
            got_v = {bus.grst, bus.busy, bus.sclk_en, bus.regsel, bus.sin};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s tick %0d {grst,busy,sclk_en,regsel,sin}: got %b expected %b",
                         tag, k, got_v, exp_v);
            end
        end
        checks++;
        if (ack_pulses !== 0) begin
            errors++;
            $display("FAIL %s extra acks in frame: got %0d expected 0", tag, ack_pulses);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.addr = '0;
        bus.data = '0;
        repeat (3) @(negedge sclk);
        checks++;
        if ({bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy, bus.ack} !== {5'b10000, 3'b000}) begin
            errors++;
            $display("FAIL reset values {grst,sin,regsel,sclk_en,busy,ack}: got %b expected %b",
                     {bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy, bus.ack}, {5'b10000, 3'b000});
        end
    endtask

    task automatic test_grst_hold();
        release_reset();
        check_grst_hold("grst_hold");
    endtask

    task automatic test_req_between_ticks();
        ack_pulses = 0;
        bus.req = 3'b001;
        repeat (100) step_cycle();
        bus.req = 3'b000;
        to_tick();
        checks++;
        if (ack_pulses !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL off_tick_req {acks,busy}: got %0d,%b expected 0,0", ack_pulses, bus.busy);
        end
    endtask

    task automatic test_single_frame();
        set_slice(0, 5'd10, 30'd35);
        bus.req = 3'b001;
        run_frame(0, 5'd10, 30'd35, 1'b1, 1'b0, "frame0");
    endtask

    task automatic test_reset_mid_data();
        set_slice(2, 5'd31, 30'h3FFF_FFFF);
        bus.req = 3'b100;
        to_tick();
        checks++;
        if (bus.ack !== 3'b100) begin
            errors++;
            $display("FAIL abort grant ack: got %b expected %b", bus.ack, 3'b100);
        end
        bus.req = 3'b000;
        repeat (10) to_tick();
        repeat (7) step_cycle();
        checks++;
        if ({bus.busy, bus.sclk_en, bus.regsel, bus.sin} !== 4'b1101) begin
            errors++;
            $display("FAIL abort pre-reset {busy,sclk_en,regsel,sin}: got %b expected %b",
                     {bus.busy, bus.sclk_en, bus.regsel, bus.sin}, 4'b1101);
        end
        @(negedge sclk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy, bus.ack} !== {5'b10000, 3'b000}) begin
            errors++;
            $display("FAIL abort reset values {grst,sin,regsel,sclk_en,busy,ack}: got %b expected %b",
                     {bus.grst, bus.sin, bus.regsel, bus.sclk_en, bus.busy, bus.ack}, {5'b10000, 3'b000});
        end
        repeat (3) @(negedge sclk);
        release_reset();
        check_grst_hold("abort_grst_hold");
        ack_pulses = 0;
        repeat (2) to_tick();
        checks++;
        if (ack_pulses !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort resend {acks,busy}: got %0d,%b expected 0,0", ack_pulses, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        set_slice(0, 5'd3,  30'h0000_0155);
        set_slice(1, 5'd22, 30'd2);
        set_slice(2, 5'd17, 30'h2AAA_AAAA);
        bus.req = 3'b111;
        run_frame(0, 5'd3,  30'h0000_0155, 1'b0, 1'b0, "rr_frame0");
        run_frame(1, 5'd22, 30'd2,         1'b0, 1'b1, "rr_frame1_capture");
        run_frame(2, 5'd17, 30'h2AAA_AAAA, 1'b0, 1'b0, "rr_frame2");
        to_tick();
        checks++;
        if (bus.ack !== 3'b001) begin
            errors++;
            $display("FAIL rr wrap ack: got %b expected %b", bus.ack, 3'b001);
        end
        bus.req = 3'b000;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors     = 0;
        checks     = 0;
        ack_pulses = 0;
        test_reset();
        test_grst_hold();
        test_req_between_ticks();
        test_single_frame();
        test_reset_mid_data();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cfg_scheduler.md
SPI_CFG_SCHEDULER -- requirements
Module: spi_cfg_scheduler

Interface
REQ-001 Parameter NREQ, default 3, number of requesters sharing the serial configuration link.
REQ-002 Parameter DIV, default 256, SCLK cycles per serial bit period (power of two, >=4).
REQ-003 Parameter GRST_BITS, default 40, bit periods GRST is held after reset.
REQ-004 Parameter ADDR_W, default 5, slave-select field width.
REQ-005 Parameter DATA_W, default 30, slave data field width.
REQ-006 The port list SHALL be, clock and reset first:
- SCLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester level request.
- ADDR  in  NREQ*ADDR_W  flattened slave addresses; requester i occupies slice i.
- DATA  in  NREQ*DATA_W  flattened data words; requester i occupies slice i.
- ACK  out  NREQ  one-SCLK capture pulse to the granted requester.
- GRST  out  1  global chip reset to slaves, active high.
- SIN  out  1  serial data.
- REGSEL  out  1  high = slave-select phase, low = data/no-op.
- SCLK_EN  out  1  serial clock gate enable, high only while a bit is driven.
- BUSY  out  1  high from grant until the end of GUARD.
REQ-007 The block SHALL use one clock (SCLK); reset (RST) is asynchronous and active-low.

Function
REQ-008 The block SHALL derive a one-SCLK bit tick every DIV SCLK cycles; all state transitions and SIN/REGSEL/SCLK_EN/GRST updates SHALL occur only on a tick.
REQ-009 The FSM SHALL have the states GRST_HOLD, IDLE, ADDR, DATA and GUARD.
REQ-010 GRST_HOLD: GRST=1, SIN=0, REGSEL=0, SCLK_EN=0 for exactly GRST_BITS ticks, then go to IDLE with GRST=0.
REQ-011 IDLE: on a tick with any REQ bit high, grant round-robin starting at the index after the last grant (index 0 first after reset), capture that requester's ADDR/DATA slices, pulse ACK[i] for that SCLK cycle, and go to ADDR.
REQ-012 REQ sampled on a non-tick cycle SHALL have no effect; REQ deasserted before the tick SHALL not be granted.
REQ-013 ADDR: REGSEL=1, SCLK_EN=1, SIN = captured address MSB-first for ADDR_W ticks, then go to DATA.
REQ-014 DATA: REGSEL=0, SCLK_EN=1, SIN = captured data LSB-first for DATA_W ticks, then go to GUARD.
REQ-015 GUARD: SIN=0, REGSEL=0, SCLK_EN=0 for one tick, then go to IDLE.
REQ-016 A full frame SHALL occupy ADDR_W+DATA_W+1 ticks from grant to IDLE (36 with defaults).
REQ-017 Captured ADDR/DATA SHALL be immune to input changes after ACK.
REQ-018 Bit counters SHALL saturate and never wrap; the round-robin pointer SHALL wrap from NREQ-1 to 0.
REQ-019 BUSY SHALL be 0 in GRST_HOLD and IDLE, and 1 otherwise.

Reset
REQ-020 While RST=0, GRST=1, SIN=0, REGSEL=0, SCLK_EN=0, ACK=0, BUSY=0, the tick divider=0, the RR pointer=0 and state=GRST_HOLD.
REQ-021 A reset asserted mid-frame SHALL abort the frame immediately; the frame is not retransmitted, and GRST_HOLD reruns on release.

Structure
REQ-022 Package spi_cfg_pkg SHALL hold the FSM state encoding and the default ADDR_W/DATA_W/DIV/GRST_BITS constants.
REQ-023 The tick generator SHALL be the sub-module spi_bit_tick (parameter DIV; ports SCLK, RST, TICK).

Verification
REQ-024 The bench SHALL cover the following scenarios:
- Reset release, no REQ -> GRST=1 for 40 ticks (10240 SCLK), then 0; SIN/REGSEL/SCLK_EN stay 0.
- REQ[0] with ADDR=10, DATA=35 -> one ACK[0] pulse; REGSEL=1 while SIN shifts 01010; then REGSEL=0 while SIN shifts 35 LSB-first (1,1,0,0,0,1,0...0); 36 ticks to IDLE.
- REQ=3'b111 held continuously -> grant order 0,1,2,0; exactly one ACK per frame; one GUARD tick between frames.
- ADDR/DATA changed one cycle after ACK[1] (slave 22, data 2) -> transmitted bits still 10110 / 2.
- RST pulsed low mid-DATA -> outputs reach reset values within one SCLK; GRST_HOLD reruns; the aborted frame is not resent.
